window_fill_buffer: RTL and testbench
=====================================

WINDOW_FILL_BUFFER -- requirements
Module: window_fill_buffer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the sample width in bits.
REQ-002 Parameter DEPTH, default 12, SHALL set the number of buffer entries (legal range 2..64).
REQ-003 Parameter STRIDE, default 3, SHALL set the entries released per consume (legal range 1..DEPTH).
REQ-004 Parameter MODE, default 0, SHALL select 0 = FILL (stop when full) or 1 = SLIDE (overwrite oldest when full).
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 n_rst  in  1  SHALL be the asynchronous active-low reset.
REQ-007 shift_enable  in  1  SHALL request insertion of read_data this cycle.
REQ-008 read_data  in  DATA_W  SHALL be the sample to insert.
REQ-009 consume  in  1  SHALL request release of STRIDE oldest entries.
REQ-010 buffer_clear  in  1  SHALL synchronously empty the buffer.
REQ-011 data_buffer  out  DEPTH x DATA_W  SHALL present all entries; index 0 newest, index DEPTH-1 oldest.
REQ-012 fill_count  out  clog2(DEPTH+1)  SHALL give the number of valid entries.
REQ-013 buffer_full  out  1  SHALL be high iff fill_count == DEPTH.
REQ-014 buffer_empty  out  1  SHALL be high iff fill_count == 0.
REQ-015 window_valid  out  1  SHALL pulse one cycle when a full window becomes available.
REQ-016 error  out  1  SHALL be a sticky flag for rejected shift or consume requests.

Function
REQ-017 State SHALL be one of EMPTY (count 0), FILLING (0<count<DEPTH), FULL (count DEPTH), derived from fill_count; outputs registered, no combinational path input->output.
REQ-018 Accepted shift SHALL load data_buffer[0]<=read_data and data_buffer[i]<=data_buffer[i-1] for i=1..DEPTH-1 in the same edge.
REQ-019 consume_ok SHALL be consume && fill_count >= STRIDE; consume_ok SHALL reduce count by STRIDE and SHALL NOT alter data_buffer contents.
REQ-020 Shift SHALL be accepted iff shift_enable && (fill_count < DEPTH || MODE==1 || consume_ok).
REQ-021 Next count SHALL be fill_count - (consume_ok ? STRIDE : 0) + (accepted shift ? 1 : 0), except MODE 1 full with shift and no consume: count stays DEPTH and oldest entry discarded.
REQ-022 Count SHALL never exceed DEPTH nor go below 0.
REQ-023 window_valid SHALL be high in the cycle after any accepted shift that leaves count == DEPTH (MODE 1: every accepted shift while full), else low.
REQ-024 error SHALL set on shift_enable not accepted (MODE 0 full, no consume_ok) or on consume with fill_count < STRIDE; it SHALL hold until buffer_clear or reset.
REQ-025 Rejected shift SHALL leave data_buffer and count unchanged; rejected consume SHALL leave count unchanged.
REQ-026 buffer_clear SHALL have top priority: next edge zero all entries, count 0, error 0, window_valid 0; simultaneous shift/consume ignored and not flagged.
REQ-027 shift_enable low SHALL hold data_buffer regardless of read_data.

Reset
REQ-028 n_rst low SHALL immediately force data_buffer all zero, fill_count 0, buffer_empty 1, buffer_full 0, window_valid 0, error 0.
REQ-029 Reset asserted mid-fill SHALL discard contents; first accepted shift after release SHALL yield count 1.

Verification (DATA_W 8, DEPTH 12, STRIDE 3)
REQ-030 MODE 0: reset, shift 0x2A,0x32,...(12 bytes) -> count 1..12, buffer_full after 12th, window_valid one pulse, data_buffer[11]=0x2A, [0]=12th byte.
REQ-031 MODE 0 full, shift 0x79 -> contents unchanged, count 12, error=1; buffer_clear -> all zero, count 0, error 0.
REQ-032 MODE 0 full, consume+shift 0x10 same cycle -> count 10, data_buffer[0]=0x10, no error.
REQ-033 MODE 1 full, three shifts 0xA1,0xA2,0xA3 -> count 12, oldest three discarded, [0]=0xA3, window_valid high three cycles.
REQ-034 Count 2, consume -> count 2, error=1; shift_enable low with changing read_data -> no change.
REQ-035 n_rst pulsed low asynchronously at count 7 -> outputs zero before next edge; next shift 0x45 -> count 1, [0]=0x45.

Source files
------------

// File: rtl/window_fill_buffer.sv
// Sample window buffer: a shift register of DEPTH entries (index 0 newest,
// index DEPTH-1 oldest) with a fill counter. A consume releases STRIDE of
// the oldest entries. MODE 0 stops accepting samples when full. MODE 1
// slides the window and discards the oldest entry on overflow.
// All outputs come from registers.
module window_fill_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 12,
    parameter int STRIDE = 3,
    parameter int MODE   = 0
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         shift_enable,
    input  logic [DATA_W-1:0]            read_data,
    input  logic                         consume,
    input  logic                         buffer_clear,
    output logic [DEPTH*DATA_W-1:0]      data_buffer,
    output logic [$clog2(DEPTH+1)-1:0]   fill_count,
    output logic                         buffer_full,
    output logic                         buffer_empty,
    output logic                         window_valid,
    output logic                         error
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STRIDE_C = CNT_W'(STRIDE);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic             SLIDE_C  = (MODE == 32'sd1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    logic [DEPTH*DATA_W-1:0] data_r;
    logic [CNT_W-1:0]        fill_count_r;
    logic                    window_valid_r;
    logic                    error_r;
    state_t                  state_r;

    logic                    consume_ok_s;
    logic                    shift_ok_s;
    logic                    reject_s;
    logic [CNT_W-1:0]        count_nx_s;
    state_t                  state_nx_s;

    // Accept/reject decisions and the next occupancy for this cycle.
    always_comb begin
        consume_ok_s = consume && (fill_count_r >= STRIDE_C);
        shift_ok_s   = shift_enable &&
                       ((fill_count_r < DEPTH_C) || SLIDE_C || consume_ok_s);
        reject_s     = (shift_enable && !shift_ok_s) || (consume && !consume_ok_s);
        count_nx_s   = fill_count_r;
        if (consume_ok_s) begin
            if (shift_ok_s) begin
                count_nx_s = fill_count_r - STRIDE_C + ONE_C;
            end else begin
                count_nx_s = fill_count_r - STRIDE_C;
            end
        end else if (shift_ok_s && (fill_count_r != DEPTH_C)) begin
            count_nx_s = fill_count_r + ONE_C;
        end else begin
            // A sliding shift while full keeps the count at DEPTH.
            count_nx_s = fill_count_r;
        end
        case (count_nx_s)
            {CNT_W{1'b0}}: state_nx_s = ST_EMPTY;
            DEPTH_C:       state_nx_s = ST_FULL;
            default:       state_nx_s = ST_FILLING;
        endcase
    end

    // Buffer contents, occupancy state and status flags. A clear takes
    // priority over any shift or consume that arrives in the same cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_r         <= {(DEPTH*DATA_W){1'b0}};
            fill_count_r   <= {CNT_W{1'b0}};
            state_r        <= ST_EMPTY;
            window_valid_r <= 1'b0;
            error_r        <= 1'b0;
        end else if (buffer_clear) begin
            data_r         <= {(DEPTH*DATA_W){1'b0}};
            fill_count_r   <= {CNT_W{1'b0}};
            state_r        <= ST_EMPTY;
            window_valid_r <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            if (shift_ok_s) begin
                data_r <= {data_r[(DEPTH-1)*DATA_W-1:0], read_data};
            end else begin
                data_r <= data_r;
            end
            fill_count_r   <= count_nx_s;
            state_r        <= state_nx_s;
            window_valid_r <= shift_ok_s && (count_nx_s == DEPTH_C);
            error_r        <= error_r || reject_s;
        end
    end

    assign data_buffer  = data_r;
    assign fill_count   = fill_count_r;
    assign buffer_full  = (state_r == ST_FULL);
    assign buffer_empty = (state_r == ST_EMPTY);
    assign window_valid = window_valid_r;
    assign error        = error_r;

endmodule

// File: tb/tb_window_fill_buffer.sv
// Bench for window_fill_buffer. It drives a FILL instance and a SLIDE
// instance with the same stimulus. An independent behavioural model
// predicts every output, and a table of hand-derived expectations covers
// the FILL instance.
module tb_window_fill_buffer;

    logic        tb_clk = 1'b0;
    logic        n_rst;
    logic        shift_enable;
    logic [7:0]  read_data;
    logic        consume;
    logic        buffer_clear;

    logic [95:0] data0, data1;
    logic [3:0]  cnt0, cnt1;
    logic        full0, full1, empty0, empty1, wv0, wv1, err0, err1;

    int checks = 0;
    int failures = 0;

    always #5 tb_clk = ~tb_clk;

    window_fill_buffer #(.DATA_W(8), .DEPTH(12), .STRIDE(3), .MODE(0)) dut0 (
        .clk(tb_clk), .n_rst(n_rst), .shift_enable(shift_enable),
        .read_data(read_data), .consume(consume), .buffer_clear(buffer_clear),
        .data_buffer(data0), .fill_count(cnt0), .buffer_full(full0),
        .buffer_empty(empty0), .window_valid(wv0), .error(err0));

    window_fill_buffer #(.DATA_W(8), .DEPTH(12), .STRIDE(3), .MODE(1)) dut1 (
        .clk(tb_clk), .n_rst(n_rst), .shift_enable(shift_enable),
        .read_data(read_data), .consume(consume), .buffer_clear(buffer_clear),
        .data_buffer(data1), .fill_count(cnt1), .buffer_full(full1),
        .buffer_empty(empty1), .window_valid(wv1), .error(err1));

    typedef struct packed {
        logic [95:0] bufv;
        logic [3:0]  cnt;
        logic        full;
        logic        empty;
        logic        wv;
        logic        err;
    } snap_t;

    typedef struct {
        logic       sh;
        logic [7:0] d;
        logic       co;
        logic       cl;
        logic [3:0] cnt;
        logic       wv;
        logic       err;
    } vec_t;

    snap_t m0, m1;
    snap_t q0[$];
    snap_t q1[$];
    vec_t  vt[$];

    function automatic snap_t reset_snap();
        snap_t r;
        r = '0;
        r.empty = 1'b1;
        return r;
    endfunction

    // Behavioural reference model, following the requirement text.
    function automatic snap_t model(input snap_t m, input int mode, input logic sh,
                                    input logic [7:0] d, input logic co, input logic cl);
        snap_t r;
        int n;
        bit cok, sok;
        r = m;
        if (cl) return reset_snap();
        cok = co && (m.cnt >= 4'd3);
        sok = sh && ((m.cnt < 4'd12) || (mode == 1) || cok);
        if ((sh && !sok) || (co && !cok)) r.err = 1'b1;
        if (sok) r.bufv = {m.bufv[87:0], d};
        n = int'(m.cnt) - (cok ? 3 : 0) + (sok ? 1 : 0);
        if (n > 12) n = 12;
        r.cnt   = 4'(n);
        r.wv    = sok && (n == 12);
        r.full  = (n == 12);
        r.empty = (n == 0);
        return r;
    endfunction

    function automatic vec_t mk(input logic sh, input logic [7:0] d, input logic co,
                                input logic cl, input int cnt, input logic wv, input logic err);
        vec_t v;
        v.sh = sh; v.d = d; v.co = co; v.cl = cl;
        v.cnt = 4'(cnt); v.wv = wv; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic compare_dut(input int idx, input snap_t e);
        snap_t a;
        if (idx == 0) a = {data0, cnt0, full0, empty0, wv0, err0};
        else          a = {data1, cnt1, full1, empty1, wv1, err1};
        chk($sformatf("sb%0d_buffer", idx), a.bufv, e.bufv);
        chk($sformatf("sb%0d_count", idx), 96'(a.cnt), 96'(e.cnt));
        chk($sformatf("sb%0d_full", idx), 96'(a.full), 96'(e.full));
        chk($sformatf("sb%0d_empty", idx), 96'(a.empty), 96'(e.empty));
        chk($sformatf("sb%0d_wv", idx), 96'(a.wv), 96'(e.wv));
        chk($sformatf("sb%0d_err", idx), 96'(a.err), 96'(e.err));
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic sh, input logic [7:0] d, input logic co, input logic cl);
        shift_enable = sh; read_data = d; consume = co; buffer_clear = cl;
        m0 = model(m0, 0, sh, d, co, cl);
        m1 = model(m1, 1, sh, d, co, cl);
        q0.push_back(m0);
        q1.push_back(m1);
        @(posedge tb_clk);
        #1;
        compare_dut(0, q0.pop_front());
        compare_dut(1, q1.pop_front());
        shift_enable = 1'b0; consume = 1'b0; buffer_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; shift_enable = 1'b0; read_data = 8'h00;
        consume = 1'b0; buffer_clear = 1'b0;
        m0 = reset_snap(); m1 = reset_snap();

        // Hand-derived vectors for the FILL instance.
        for (int i = 0; i < 12; i++)
            vt.push_back(mk(1'b1, 8'(8'h2A + 8 * i), 1'b0, 1'b0, i + 1, (i == 11), 1'b0));
        vt.push_back(mk(1'b1, 8'h79, 1'b0, 1'b0, 12, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 12, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0));
        for (int i = 0; i < 12; i++)
            vt.push_back(mk(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, i + 1, (i == 11), 1'b0));
        vt.push_back(mk(1'b1, 8'h10, 1'b1, 1'b0, 10, 1'b0, 1'b0));

        // Reset state, before any clock edge.
        #2;
        chk("rst_buffer0", data0, 96'h0);
        chk("rst_count0", 96'(cnt0), 96'h0);
        chk("rst_empty0", 96'(empty0), 96'h1);
        chk("rst_full0", 96'(full0), 96'h0);
        chk("rst_wv0", 96'(wv0), 96'h0);
        chk("rst_err0", 96'(err0), 96'h0);
        chk("rst_count1", 96'(cnt1), 96'h0);
        @(negedge tb_clk);
        n_rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].sh, vt[i].d, vt[i].co, vt[i].cl);
            chk($sformatf("vec%0d_count", i), 96'(cnt0), 96'(vt[i].cnt));
            chk($sformatf("vec%0d_wv", i), 96'(wv0), 96'(vt[i].wv));
            chk($sformatf("vec%0d_err", i), 96'(err0), 96'(vt[i].err));
            if (i == 11) begin
                chk("fill_oldest", 96'(data0[95:88]), 96'h2A);
                chk("fill_newest", 96'(data0[7:0]), 96'h82);
                chk("fill_full", 96'(full0), 96'h1);
            end
            if (i == 14) chk("clear_buffer", data0, 96'h0);
            if (i == vt.size() - 1) chk("cons_shift_d0", 96'(data0[7:0]), 96'h10);
        end

        // SLIDE: fill to DEPTH, then three overflowing shifts.
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        chk("slide_full", 96'(cnt1), 96'd12);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'(8'hA1 + k), 1'b0, 1'b0);
            chk($sformatf("slide_wv%0d", k), 96'(wv1), 96'h1);
            chk($sformatf("slide_cnt%0d", k), 96'(cnt1), 96'd12);
        end
        chk("slide_d0", 96'(data1[7:0]), 96'hA3);
        chk("slide_err", 96'(err1), 96'h0);
        chk("fill_overflow_err", 96'(err0), 96'h1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("slide_wv_drop", 96'(wv1), 96'h0);

        // Consume with too few entries, then idle cycles with changing data.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("short_cons_cnt", 96'(cnt0), 96'd2);
        chk("short_cons_err", 96'(err0), 96'h1);
        for (int k = 0; k < 4; k++)
            step(1'b0, 8'($urandom_range(255)), 1'b0, 1'b0);
        chk("hold_buffer", 96'(data0[15:0]), 96'h5566);

        // Asynchronous reset mid-fill.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++)
            step(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
        chk("pre_rst_cnt", 96'(cnt0), 96'd7);
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_buffer", data0, 96'h0);
        chk("arst_count", 96'(cnt0), 96'h0);
        chk("arst_empty", 96'(empty0), 96'h1);
        chk("arst_count1", 96'(cnt1), 96'h0);
        m0 = reset_snap(); m1 = reset_snap();
        @(posedge tb_clk);
        #1;
        n_rst = 1'b1;
        step(1'b1, 8'h45, 1'b0, 1'b0);
        chk("post_rst_cnt", 96'(cnt0), 96'd1);
        chk("post_rst_d0", 96'(data0[7:0]), 96'h45);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
